fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences the program counter and the instruction-memory port for the single-issue core.
Holds the PC register, issues one fetch request at a time over a req/ack handshake, and presents each fetched instruction to decode over a valid/ready handshake.
Accepts branch/jump redirects from execute at any point, including while a fetch is outstanding, and discards the stale response.
Sits between instruction memory and decode; it replaces free-running PC increment with handshake-controlled stepping.

Parameters:
WIDTH, 8, PC / instruction address width in bits
RESET_PC, 0, PC value loaded on reset (WIDTH bits)
INSTR_W, 32, instruction word width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  WIDTH  fetch address; equals PC while imem_req=1
imem_ack  input  1  memory response valid; imem_rdata is sampled in the same cycle
imem_rdata  input  INSTR_W  fetched instruction word
instr_valid  output  1  instruction held for decode
instr  output  INSTR_W  held instruction
instr_pc  output  WIDTH  address of the held instruction
instr_ready  input  1  decode accepts instruction (fire = instr_valid & instr_ready)
redirect  input  1  single-cycle redirect pulse from execute
redirect_target  input  WIDTH  new PC, valid when redirect=1
pc_out  output  WIDTH  current PC register value

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, pc=RESET_PC
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0
  - redir_pend=0, redir_tgt=0
  - Reset may arrive mid-fetch. Any outstanding ack arriving after reset deassertion is ignored, because the FSM is in IDLE.
- Outputs:
  - imem_req is combinational from state: 1 only in FETCH.
  - imem_addr=pc at all times.
  - pc_out=pc.
- IDLE: takes one cycle, then goes to FETCH. If redirect occurs in IDLE, pc<=redirect_target.
- FETCH: imem_req=1, and imem_addr stays stable until imem_ack.
  - redirect=1 without ack: redir_tgt<=redirect_target and redir_pend<=1. A later redirect overwrites the stored target (last wins).
  - ack with redirect=1 in the same cycle: drop imem_rdata, pc<=redirect_target, redir_pend<=0, remain in FETCH. The new request goes out the next cycle.
  - ack with redir_pend=1 (no redirect this cycle): drop data, pc<=redir_tgt, redir_pend<=0, remain in FETCH.
  - ack with no redirect pending: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to HOLD.
- HOLD: imem_req=0, instr_valid=1, and instr/instr_pc are stable until fire.
  - redirect=1: instr_valid<=0, pc<=redirect_target, go to FETCH. This happens whether or not ready is high; the held instruction is consumed if fire occurs in the same cycle, otherwise it is squashed.
  - fire without redirect: instr_valid<=0, go to FETCH.
  - otherwise remain in HOLD.
- Arithmetic: pc+4 is modulo 2^WIDTH (wraps, no flag). redirect_target is used unmodified (no alignment masking).
- Throughput: with ack in the first FETCH cycle and immediate ready, one instruction per 2 cycles. Redirect-to-first-request latency is 1 cycle.
- imem_ack outside FETCH is ignored.
- instr_ready outside HOLD is ignored.

Test Plan:
- Reset and straight-line fetch: rst low→high, ack every FETCH cycle, ready=1.
  - instr_pc sequence is 0x00, 0x04, 0x08.
  - imem_req=0 during the first cycle after reset.
  - instr_valid pulses every 2 cycles.
- Memory wait states: ack delayed 3 cycles at pc=0x10.
  - imem_req and imem_addr=0x10 hold for 4 cycles.
  - instr_pc=0x10; pc_out becomes 0x14 after ack.
- Decode backpressure: ready=0 for 5 cycles with instr=0xDEADBEEF held.
  - instr and instr_pc are unchanged and imem_req=0 throughout.
  - After the single fire, the next fetch goes to pc+4.
- Redirect during outstanding fetch: pc=0x20, redirect to 0x40 two cycles before ack.
  - The ack data is not presented.
  - Next imem_addr=0x40 and the next instr_pc=0x40.
- Redirect in HOLD without ready, and redirect+ack same cycle (target 0x80):
  - HOLD case: instr_valid drops the next cycle with no fire.
  - Same-cycle case: next imem_addr=0x80.
- Wrap and async reset: pc=0xFC fetch gives next pc=0x00. Asserting rst mid-FETCH clears imem_req and instr_valid immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a time,
// and holds each fetched word for decode until it is accepted or squashed by a redirect.
module fetch_ctrl #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [WIDTH-1:0]   redirect_target,
  output logic [WIDTH-1:0]   pc_out
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_pc, w_pc_next;
  logic [WIDTH-1:0]   r_redir_tgt, w_redir_tgt_next;
  logic               r_redir_pend, w_redir_pend_next;
  logic               r_valid, w_valid_next;
  logic [INSTR_W-1:0] r_instr, w_instr_next;
  logic [WIDTH-1:0]   r_instr_pc, w_instr_pc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_redir_tgt  <= '0;
      r_redir_pend <= 1'b0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_instr_pc   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_redir_tgt  <= w_redir_tgt_next;
      r_redir_pend <= w_redir_pend_next;
      r_valid      <= w_valid_next;
      r_instr      <= w_instr_next;
      r_instr_pc   <= w_instr_pc_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_redir_tgt_next  = r_redir_tgt;
    w_redir_pend_next = r_redir_pend;
    w_valid_next      = r_valid;
    w_instr_next      = r_instr;
    w_instr_pc_next   = r_instr_pc;
    case (r_state)
      IDLE: begin
        if (redirect) w_pc_next = redirect_target;
        w_state_next = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            w_pc_next         = redirect_target;
            w_redir_pend_next = 1'b0;
          end else if (r_redir_pend) begin
            w_pc_next         = r_redir_tgt;
            w_redir_pend_next = 1'b0;
          end else begin
            w_instr_next    = imem_rdata;
            w_instr_pc_next = r_pc;
            w_valid_next    = 1'b1;
            w_pc_next       = r_pc + WIDTH'(4);
            w_state_next    = HOLD;
          end
        end else if (redirect) begin
          // The address must stay stable while the request is outstanding, so park the target.
          w_redir_tgt_next  = redirect_target;
          w_redir_pend_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_valid_next = 1'b0;
          w_pc_next    = redirect_target;
          w_state_next = FETCH;
        end else if (instr_ready) begin
          w_valid_next = 1'b0;
          w_state_next = FETCH;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scenario bench for fetch_ctrl: each task drives a fetch scenario and checks
// presented instructions against a scoreboard filled as memory responses are issued.
module tb_fetch_ctrl;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_target = '0;
  logic [7:0]  pc_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_pc;
  exp_t        sb_q[$];
  exp_t        e;

  fetch_ctrl #(.WIDTH(8), .RESET_PC(8'h00), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, ~a, 8'hA5, a ^ 8'h3C};
  endfunction

  function automatic exp_t pop_exp();
    exp_t x;
    x.pc = 'x;
    x.data = 'x;
    if (sb_q.size() != 0) x = sb_q.pop_front();
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b1; redirect = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({imem_req, instr_valid, pc_out, instr_pc, instr} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got req=%0b valid=%0b pc=%h ipc=%h instr=%h exp all zero",
               imem_req, instr_valid, pc_out, instr_pc, instr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_after_reset got req=%0b addr=%h exp req=0 addr=00", imem_req, imem_addr);
    end
    $display("reset: released, first cycle idle");
    @(negedge clk);
    exp_pc = 8'h00;
  endtask

  task automatic test_straight();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        n_checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc) begin
          n_fail++;
          $display("FAIL straight_fetch got req=%0b valid=%0b addr=%h exp req=1 valid=0 addr=%h",
                   imem_req, instr_valid, imem_addr, exp_pc);
        end
        imem_ack = 1'b1; imem_rdata = mem_word(exp_pc);
        sb_q.push_back('{pc: exp_pc, data: mem_word(exp_pc)});
        exp_pc = exp_pc + 8'd4;
      end else begin
        e = pop_exp();
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.data
            || pc_out !== exp_pc) begin
          n_fail++;
          $display("FAIL straight_hold got valid=%0b ipc=%h instr=%h pc=%h exp valid=1 ipc=%h instr=%h pc=%h",
                   instr_valid, instr_pc, instr, pc_out, e.pc, e.data, exp_pc);
        end
        $display("straight: instr_pc=%h instr=%h", instr_pc, instr);
        imem_ack = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin
        n_fail++;
        $display("FAIL wait_hold_addr cycle %0d got req=%0b addr=%h exp req=1 addr=10", k, imem_req, imem_addr);
      end
      imem_ack = (k == 3);
      imem_rdata = mem_word(8'h10);
      @(negedge clk);
    end
    sb_q.push_back('{pc: 8'h10, data: mem_word(8'h10)});
    exp_pc = 8'h14;
    e = pop_exp();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.data || pc_out !== 8'h14) begin
      n_fail++;
      $display("FAIL wait_result got valid=%0b ipc=%h instr=%h pc=%h exp valid=1 ipc=%h instr=%h pc=14",
               instr_valid, instr_pc, instr, pc_out, e.pc, e.data);
    end
    $display("wait_states: instr_pc=%h pc_out=%h", instr_pc, pc_out);
    imem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h14) begin
      n_fail++;
      $display("FAIL bp_fetch got req=%0b addr=%h exp req=1 addr=14", imem_req, imem_addr);
    end
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    sb_q.push_back('{pc: 8'h14, data: 32'hDEADBEEF});
    exp_pc = 8'h18;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'hDEADBEEF || instr_pc !== 8'h14) begin
        n_fail++;
        $display("FAIL bp_stable cycle %0d got valid=%0b req=%0b instr=%h ipc=%h exp valid=1 req=0 instr=deadbeef ipc=14",
                 c, instr_valid, imem_req, instr, instr_pc);
      end
      imem_ack = 1'b1; imem_rdata = 32'h12345678;
      instr_ready = (c == 4);
      if (c == 4) begin
        e = pop_exp();
        n_checks++;
        if (instr !== e.data || instr_pc !== e.pc) begin
          n_fail++;
          $display("FAIL bp_fire got instr=%h ipc=%h exp instr=%h ipc=%h", instr, instr_pc, e.data, e.pc);
        end
        $display("backpressure: fire instr_pc=%h instr=%h", instr_pc, instr);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        n_checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc) begin
          n_fail++;
          $display("FAIL bp_next_fetch got req=%0b valid=%0b addr=%h exp req=1 valid=0 addr=%h",
                   imem_req, instr_valid, imem_addr, exp_pc);
        end
        imem_ack = 1'b1; imem_rdata = mem_word(exp_pc);
        sb_q.push_back('{pc: exp_pc, data: mem_word(exp_pc)});
        exp_pc = exp_pc + 8'd4;
      end else begin
        e = pop_exp();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.data) begin
          n_fail++;
          $display("FAIL bp_next_hold got valid=%0b ipc=%h instr=%h exp valid=1 ipc=%h instr=%h",
                   instr_valid, instr_pc, instr, e.pc, e.data);
        end
        imem_ack = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_fetch();
    redirect = 1'b1; redirect_target = 8'h60; imem_ack = 1'b0;
    @(negedge clk);
    redirect = 1'b1; redirect_target = 8'h40;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h20 || pc_out !== 8'h20) begin
      n_fail++;
      $display("FAIL redir_addr_stable got req=%0b addr=%h pc=%h exp req=1 addr=20 pc=20", imem_req, imem_addr, pc_out);
    end
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_refetch got req=%0b addr=%h valid=%0b exp req=1 addr=40 valid=0", imem_req, imem_addr, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(8'h40);
    sb_q.push_back('{pc: 8'h40, data: mem_word(8'h40)});
    exp_pc = 8'h44;
    @(negedge clk);
    e = pop_exp();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.data) begin
      n_fail++;
      $display("FAIL redir_result got valid=%0b ipc=%h instr=%h exp valid=1 ipc=%h instr=%h",
               instr_valid, instr_pc, instr, e.pc, e.data);
    end
    $display("redirect_fetch: instr_pc=%h instr=%h", instr_pc, instr);
    imem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_redirect_hold();
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(8'h44);
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h44) begin
      n_fail++;
      $display("FAIL hold_presented got valid=%0b ipc=%h exp valid=1 ipc=44", instr_valid, instr_pc);
    end
    imem_ack = 1'b0; redirect = 1'b1; redirect_target = 8'h60;
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h60) begin
      n_fail++;
      $display("FAIL hold_squash got valid=%0b req=%0b addr=%h exp valid=0 req=1 addr=60", instr_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0BAD0BAD; redirect = 1'b1; redirect_target = 8'h80;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h80 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_redirect_same got req=%0b addr=%h valid=%0b exp req=1 addr=80 valid=0", imem_req, imem_addr, instr_valid);
    end
    redirect = 1'b0; instr_ready = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(8'h80);
    sb_q.push_back('{pc: 8'h80, data: mem_word(8'h80)});
    exp_pc = 8'h84;
    @(negedge clk);
    e = pop_exp();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.data) begin
      n_fail++;
      $display("FAIL ack_redirect_result got valid=%0b ipc=%h instr=%h exp valid=1 ipc=%h instr=%h",
               instr_valid, instr_pc, instr, e.pc, e.data);
    end
    $display("redirect_hold: instr_pc=%h instr=%h", instr_pc, instr);
    imem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap_async_reset();
    imem_ack = 1'b1; imem_rdata = 32'h0; redirect = 1'b1; redirect_target = 8'hFC;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'hFC) begin
      n_fail++;
      $display("FAIL wrap_fetch got req=%0b addr=%h exp req=1 addr=fc", imem_req, imem_addr);
    end
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(8'hFC);
    sb_q.push_back('{pc: 8'hFC, data: mem_word(8'hFC)});
    exp_pc = 8'hFC + 8'd4;
    @(negedge clk);
    e = pop_exp();
    n_checks++;
    if (pc_out !== exp_pc || instr_pc !== e.pc || instr !== e.data) begin
      n_fail++;
      $display("FAIL wrap_pc got pc=%h ipc=%h instr=%h exp pc=%h ipc=%h instr=%h",
               pc_out, instr_pc, instr, exp_pc, e.pc, e.data);
    end
    $display("wrap: instr_pc=%h pc_out=%h", instr_pc, pc_out);
    imem_ack = 1'b0;
    @(negedge clk);
    redirect = 1'b1; redirect_target = 8'h30;
    @(negedge clk);
    redirect = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, pc_out, instr_pc, instr} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got req=%0b valid=%0b pc=%h ipc=%h instr=%h exp all zero",
               imem_req, instr_valid, pc_out, instr_pc, instr);
    end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF0000; redirect = 1'b1; redirect_target = 8'h50;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h50 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_redirect got req=%0b addr=%h valid=%0b exp req=1 addr=50 valid=0", imem_req, imem_addr, instr_valid);
    end
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(8'h50);
    sb_q.push_back('{pc: 8'h50, data: mem_word(8'h50)});
    @(negedge clk);
    e = pop_exp();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.data) begin
      n_fail++;
      $display("FAIL post_reset_fetch got valid=%0b ipc=%h instr=%h exp valid=1 ipc=%h instr=%h",
               instr_valid, instr_pc, instr, e.pc, e.data);
    end
    $display("async_reset: recovered, instr_pc=%h", instr_pc);
    imem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_straight();
    test_wait_states();
    test_backpressure();
    test_redirect_fetch();
    test_redirect_hold();
    test_wrap_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries left exp 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
